decim_mac_fir_param: RTL and testbench
======================================

Name: decim_mac_fir_param

Overview:
- Parametrised successor to the fixed 10-tap single-multiplier decimating FIR.
- Time-multiplexes one signed multiplier over a true NTAPS-deep sample history.
- Emits one output every DECIM accepted inputs, using valid/ready handshakes on both sides.
- Coefficients are run-time programmable; output has rounding and saturation. Sits between the ADC sample stream and downstream rate-reduced DSP.

Parameters:
- DATA_W, 8, signed input sample width.
- COEF_W, 8, signed coefficient width.
- NTAPS, 10, number of taps and history depth (2..64).
- DECIM, 10, decimation factor (1..64).
- OUT_W, 16, signed output width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  OUT_W  signed filtered, decimated sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(NTAPS)  tap index k.
- coef_wdata  in  COEF_W  signed coefficient value.
- coef_err  out  1  one-cycle pulse: write dropped (busy or address >= NTAPS).
- flush  in  1  clears history and phase without touching coefficients.

Behaviour:
- Single clock and reset:
  - one clock, clk;
  - reset rst is synchronous and active-high.
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, coef_err=0;
  - history all zero, phase=0, accumulator=0;
  - coefficients h[k]=k+1 (k=0..NTAPS-1).
- Accumulator width: ACC_W = DATA_W + COEF_W + clog2(NTAPS). Products are signed full-precision and sign-extended before accumulation.
- Filter definition: y = sum over k of h[k]*x[n-k], where x[n] is the DECIM-th accepted sample of the current group and x[n-k] is the k-th older sample.
- COLLECT state:
  - in_ready=1.
  - Accept on in_valid && in_ready: write the sample to the circular history and advance the write pointer, wrapping at NTAPS.
  - phase increments on each accept; when phase==DECIM-1 it returns to 0 and the state goes to MAC.
- MAC state:
  - in_ready=0; runs for exactly NTAPS cycles.
  - Each cycle: acc += h[k]*x[n-k], k=0..NTAPS-1. acc is cleared at MAC entry.
- OUT state:
  - out_data = sat(round(acc >>> SHIFT)), held stable while out_valid=1 && !out_ready.
  - Rounding is half-up (add 2^(SHIFT-1) before the shift when SHIFT>0).
  - sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The OUT_W-bit result is registered on MAC exit.
  - On out_ready, out_valid drops and the state goes to COLLECT.
- Latency: DECIM-th sample accepted at cycle t -> MAC runs t+1..t+NTAPS -> out_valid=1 at t+NTAPS+1.
- Throughput: maximum one output per DECIM+NTAPS+1 cycles.
- Coefficient writes:
  - Accepted in COLLECT and OUT.
  - In MAC they are dropped and coef_err pulses the next cycle.
  - coef_addr >= NTAPS is dropped and also pulses coef_err.
  - A write in the same cycle as MAC entry is treated as taking effect before MAC.
- flush:
  - Highest priority after rst. Zeroes history, phase, acc and out_valid.
  - State goes to COLLECT; coefficients are untouched.
  - A simultaneous in_valid sample is discarded.
- Reset mid-MAC or mid-OUT: a pending output is lost and coefficients return to their defaults.
- DECIM=1: every accepted sample triggers MAC.
- NTAPS > DECIM: history spans groups, so older samples come from previous groups.

Decomposition:
- Package decim_fir_pkg:
  - state enum {COLLECT, MAC, OUT};
  - width helper functions (acc width, address width);
  - default-coefficient function;
  - saturate/round function.
- Sub-module fir_hist_buf: NTAPS-deep circular sample store with a write port and a combinational read-by-offset port (x[n-k]), plus a clear input.
- Coefficient register file and FSM live in the top level.

Test Plan:
- Defaults, DECIM=NTAPS=10, input constant 1 for 10 samples -> out_data=55; out_valid rises exactly 11 cycles after the 10th accept.
- Impulse: x=1 then 9 zeros -> first out_data=10 (h[9]). Next group of 10 zeros -> 0.
- Program all h=127, input constant 127 for 10 samples -> 161290 saturates to 32767. Constant -128 -> saturates to -32768.
- SHIFT=2, defaults, constant 3 -> acc=165, round(165/4)=41.25 -> out_data=41. Constant 2 -> 110/4=27.5 -> 28.
- Backpressure: out_ready=0 for 20 cycles -> out_data stable, in_ready=0 throughout, no input lost. A coef write during MAC -> coef_err pulse and output unchanged.
- NTAPS=10, DECIM=4, ramp input 1,2,3,… -> output m equals the reference-model sum over the last 10 samples. A flush mid-group -> next output uses only post-flush samples (zeros before).

Source files
------------

// File: rtl/decim_fir_pkg.sv
// Shared types and helpers for the parametrised decimating MAC FIR.
// Widths are derived from the parameters here so the RTL and its users agree.
package decim_fir_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    OUT     = 2'd2
  } state_t;

  function automatic int addr_width(input int ntaps);
    return (ntaps > 1) ? $clog2(ntaps) : 1;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  function automatic int default_coef(input int k);
    return k + 1;
  endfunction

  // Half-up rounding on the arithmetic shift, then clamp into an out_w-bit signed range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift, input int out_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = acc;
    if (shift > 0) v = (v + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_hist_buf.sv
// NTAPS-deep circular sample history. Offset k on the read port returns the
// k-th sample older than the newest one written, combinationally.
module fir_hist_buf #(
  parameter int DATA_W = 8,
  parameter int NTAPS  = 10,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_rd_off,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [NTAPS];
  logic [AW-1:0]     r_wptr;
  logic [AW:0]       w_idx;

  // Newest sample sits at wptr-1; one conditional subtract wraps the index.
  always_comb begin
    w_idx = {1'b0, r_wptr} + (AW+1)'(NTAPS - 1) - {1'b0, i_rd_off};
    if (w_idx >= (AW+1)'(NTAPS)) w_idx = w_idx - (AW+1)'(NTAPS);
  end

  assign o_rd_data = r_mem[w_idx[AW-1:0]];

  // NOTE: the history is reset as well, because the filter reads taps that
  // were never written and they must contribute zero.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < NTAPS; i++) r_mem[i] <= '0;
      r_wptr <= '0;
    end else if (i_we) begin
      r_mem[r_wptr] <= i_wdata;
      r_wptr        <= (r_wptr == AW'(NTAPS - 1)) ? '0 : r_wptr + AW'(1);
    end
  end

endmodule

// File: rtl/decim_mac_fir_param.sv
// Decimating FIR sharing one signed multiplier across NTAPS taps, with
// run-time coefficients, valid/ready on both sides, rounding and saturation.
module decim_mac_fir_param
  import decim_fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int NTAPS  = 10,
  parameter int DECIM  = 10,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  input  logic                        coef_we,
  input  logic [addr_width(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]           coef_wdata,
  output logic                        coef_err,
  input  logic                        flush
);

  localparam int AW    = addr_width(NTAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int PW    = $clog2(DECIM + 1);
  localparam int PRD_W = DATA_W + COEF_W;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [PW-1:0]              r_phase;
  logic [AW-1:0]              r_k;
  logic signed [ACC_W-1:0]    r_acc;
  logic [OUT_W-1:0]           r_out_data;
  logic signed [COEF_W-1:0]   r_coef [NTAPS];
  logic                       r_coef_err;

  logic                       w_accept;
  logic                       w_group_done;
  logic                       w_mac_last;
  logic                       w_addr_ok;
  logic [DATA_W-1:0]          w_hist_rd;
  logic signed [DATA_W-1:0]   w_x;
  logic signed [PRD_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_acc_next;

  assign w_accept     = in_valid && (r_state == COLLECT) && !flush;
  assign w_group_done = w_accept && (r_phase == PW'(DECIM - 1));
  assign w_mac_last   = (r_state == MAC) && (r_k == AW'(NTAPS - 1));
  assign w_addr_ok    = ({1'b0, coef_addr} < (AW+1)'(NTAPS));

  fir_hist_buf #(
    .DATA_W (DATA_W),
    .NTAPS  (NTAPS),
    .AW     (AW)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (flush),
    .i_we      (w_accept),
    .i_wdata   (in_data),
    .i_rd_off  (r_k),
    .o_rd_data (w_hist_rd)
  );

  assign w_x        = w_hist_rd;
  assign w_prod     = r_coef[r_k] * w_x;
  assign w_prod_ext = {{(ACC_W - PRD_W){w_prod[PRD_W-1]}}, w_prod};
  assign w_acc_next = r_acc + w_prod_ext;

  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_state_next;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (w_group_done) w_state_next = MAC;
        MAC:     if (w_mac_last)   w_state_next = OUT;
        OUT:     if (out_ready)    w_state_next = COLLECT;
        default:                   w_state_next = COLLECT;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == COLLECT);
    out_valid = (r_state == OUT);
  end

  // Datapath: phase counter, tap counter, accumulator and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase    <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else if (flush) begin
      r_phase <= '0;
      r_k     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_group_done) begin
            r_phase <= '0;
            r_k     <= '0;
            r_acc   <= '0;
          end else if (w_accept) begin
            r_phase <= r_phase + PW'(1);
          end
        end
        MAC: begin
          r_acc <= w_acc_next;
          r_k   <= w_mac_last ? '0 : r_k + AW'(1);
          if (w_mac_last)
            r_out_data <= OUT_W'(sat_round(64'(w_acc_next), SHIFT, OUT_W));
        end
        default: ;
      endcase
    end
  end

  // Writes are refused while the MAC is reading the coefficient file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) r_coef[k] <= COEF_W'(default_coef(k));
      r_coef_err <= 1'b0;
    end else begin
      r_coef_err <= coef_we && ((r_state == MAC) || !w_addr_ok);
      if (coef_we && (r_state != MAC) && w_addr_ok)
        r_coef[coef_addr] <= coef_wdata;
    end
  end

  assign out_data = r_out_data;
  assign coef_err = r_coef_err;

endmodule

// File: tb/tb_decim_mac_fir_param.sv
// Randomised bench for decim_mac_fir_param: two instances (DECIM=10/SHIFT=0 and
// DECIM=4/SHIFT=2) are checked against a sample-history reference model.
module tb_decim_mac_fir_param;

  localparam int NT = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_v       [2];
  logic        in_valid_v  [2];
  logic        in_ready_v  [2];
  logic [7:0]  in_data_v   [2];
  logic        out_valid_v [2];
  logic        out_ready_v [2];
  logic [15:0] out_data_v  [2];
  logic        coef_we_v   [2];
  logic [3:0]  coef_addr_v [2];
  logic [7:0]  coef_wdata_v[2];
  logic        coef_err_v  [2];
  logic        flush_v     [2];

  decim_mac_fir_param #(
    .DATA_W(8), .COEF_W(8), .NTAPS(NT), .DECIM(10), .OUT_W(16), .SHIFT(0)
  ) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data_v[0]), .coef_we(coef_we_v[0]), .coef_addr(coef_addr_v[0]),
    .coef_wdata(coef_wdata_v[0]), .coef_err(coef_err_v[0]), .flush(flush_v[0])
  );

  decim_mac_fir_param #(
    .DATA_W(8), .COEF_W(8), .NTAPS(NT), .DECIM(4), .OUT_W(16), .SHIFT(2)
  ) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data_v[1]), .coef_we(coef_we_v[1]), .coef_addr(coef_addr_v[1]),
    .coef_wdata(coef_wdata_v[1]), .coef_err(coef_err_v[1]), .flush(flush_v[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: coefficients, last NT accepted samples (index 0 newest).
  int          mh    [2][NT];
  int          mhist [2][NT];
  int          mphase[2];
  int          mexp  [2];
  int unsigned acc_cyc[2];

  function automatic int dec_of(input int s);
    return (s == 0) ? 10 : 4;
  endfunction

  function automatic int shift_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_out(input longint acc, input int shift);
    longint d, num, q;
    if (shift > 0) begin
      d   = longint'(1) << shift;
      num = acc + d / 2;
      q   = num / d;
      if ((num % d != 0) && (num < 0)) q = q - 1;
    end else begin
      q = acc;
    end
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int model_y(input int s);
    longint acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'(mh[s][k]) * longint'(mhist[s][k]);
    return ref_out(acc, shift_of(s));
  endfunction

  task automatic model_clear_hist(input int s);
    for (int k = 0; k < NT; k++) mhist[s][k] = 0;
    mphase[s] = 0;
  endtask

  task automatic model_reset(input int s);
    for (int k = 0; k < NT; k++) mh[s][k] = k + 1;
    model_clear_hist(s);
    mexp[s] = 0;
  endtask

  task automatic model_push(input int s, input int x);
    for (int k = NT - 1; k > 0; k--) mhist[s][k] = mhist[s][k-1];
    mhist[s][0] = x;
    mphase[s]++;
    if (mphase[s] == dec_of(s)) begin
      mphase[s] = 0;
      mexp[s]   = model_y(s);
    end
  endtask

  task automatic send(input int s, input int x);
    int n = 0;
    @(negedge clk);
    in_valid_v[s] = 1'b1;
    in_data_v[s]  = 8'(x);
    while (!in_ready_v[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_v[s]) begin
      check("send_timeout", 0, 1);
      in_valid_v[s] = 1'b0;
      return;
    end
    acc_cyc[s] = cyc;
    @(posedge clk);
    model_push(s, x);
    #1 in_valid_v[s] = 1'b0;
  endtask

  task automatic send_const(input int s, input int x, input int cnt);
    for (int i = 0; i < cnt; i++) send(s, x);
  endtask

  task automatic send_rand(input int s, input int cnt);
    for (int i = 0; i < cnt; i++) send(s, int'($urandom_range(255)) - 128);
  endtask

  task automatic get_out(input int s, input string tag, input bit lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid_v[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_v[s]) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check(tag, int'($signed(out_data_v[s])), mexp[s]);
    if (lat) check({tag, "_latency"}, int'(cyc - acc_cyc[s]), NT + 1);
    out_ready_v[s] = 1'b1;
    @(posedge clk);
    #1 out_ready_v[s] = 1'b0;
  endtask

  task automatic write_coef(input int s, input int addr, input int val,
                            input bit exp_err, input string tag);
    @(negedge clk);
    coef_we_v[s]    = 1'b1;
    coef_addr_v[s]  = 4'(addr);
    coef_wdata_v[s] = 8'(val);
    @(posedge clk);
    #1 coef_we_v[s] = 1'b0;
    @(negedge clk);
    check(tag, int'(coef_err_v[s]), int'(exp_err));
    if (!exp_err) mh[s][addr] = val;
  endtask

  task automatic do_flush(input int s);
    @(negedge clk);
    flush_v[s]    = 1'b1;
    in_valid_v[s] = 1'b1;
    in_data_v[s]  = 8'd77;
    @(posedge clk);
    #1;
    flush_v[s]    = 1'b0;
    in_valid_v[s] = 1'b0;
    model_clear_hist(s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit stable_ok;
    bit rdy_seen;
    int n;
    logic [15:0] held;

    for (int s = 0; s < 2; s++) begin
      rst_v[s] = 1'b1; in_valid_v[s] = 1'b0; in_data_v[s] = '0; out_ready_v[s] = 1'b0;
      coef_we_v[s] = 1'b0; coef_addr_v[s] = '0; coef_wdata_v[s] = '0; flush_v[s] = 1'b0;
      model_reset(s);
    end
    repeat (3) @(posedge clk);
    #1 rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    @(negedge clk);
    check("rst_in_ready",  int'(in_ready_v[0]), 1);
    check("rst_out_valid", int'(out_valid_v[0]), 0);
    check("rst_out_data",  int'(out_data_v[0]), 0);
    check("rst_coef_err",  int'(coef_err_v[0]), 0);
    check("rst_in_ready1", int'(in_ready_v[1]), 1);

    // ---- instance 0: DECIM=10, SHIFT=0 ----
    send_const(0, 1, 10);
    get_out(0, "const1", 1'b1);

    send(0, 1);
    send_const(0, 0, 9);
    get_out(0, "impulse", 1'b0);
    send_const(0, 0, 10);
    get_out(0, "zeros", 1'b0);

    for (int k = 0; k < NT; k++) write_coef(0, k, 127, 1'b0, "cw127");
    send_const(0, 127, 10);
    get_out(0, "sat_pos", 1'b0);
    send_const(0, -128, 10);
    get_out(0, "sat_neg", 1'b0);

    // Backpressure with a refused coefficient write during MAC.
    send_const(0, 1, 10);
    write_coef(0, 0, 99, 1'b1, "cw_in_mac");
    n = 0;
    while (!out_valid_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", int'(out_valid_v[0]), 1);
    held = out_data_v[0];
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = 8'd5;
    stable_ok = 1'b1;
    rdy_seen  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_data_v[0] !== held || !out_valid_v[0]) stable_ok = 1'b0;
      if (in_ready_v[0]) rdy_seen = 1'b1;
    end
    check("bp_stable", int'(stable_ok), 1);
    check("bp_in_ready_low", int'(rdy_seen), 0);
    get_out(0, "bp_data", 1'b0);
    send(0, 5);
    send_const(0, 1, 9);
    get_out(0, "after_stall", 1'b0);

    write_coef(0, 12, 3, 1'b1, "cw_bad_addr");

    for (int k = 0; k < NT; k++)
      write_coef(0, k, int'($urandom_range(255)) - 128, 1'b0, "cw_rand");
    for (int g = 0; g < 3; g++) begin
      send_rand(0, 10);
      get_out(0, "rand0", 1'b0);
    end

    // Reset mid-MAC: pending output dropped, defaults restored.
    send_rand(0, 10);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1 rst_v[0] = 1'b0;
    model_reset(0);
    @(negedge clk);
    check("midmac_rst_out_valid", int'(out_valid_v[0]), 0);
    check("midmac_rst_in_ready",  int'(in_ready_v[0]), 1);
    send_const(0, 1, 10);
    get_out(0, "post_rst_const1", 1'b1);

    // ---- instance 1: DECIM=4, SHIFT=2 ----
    for (int g = 0; g < 3; g++) begin
      send_const(1, 3, 4);
      get_out(1, "shift_const3", (g == 2));
    end
    for (int g = 0; g < 3; g++) begin
      send_const(1, 2, 4);
      get_out(1, "shift_const2", 1'b0);
    end
    for (int g = 0; g < 4; g++) begin
      for (int i = 1; i <= 4; i++) send(1, g * 4 + i);
      get_out(1, "ramp", 1'b0);
    end

    send_rand(1, 2);
    do_flush(1);
    send_const(1, 7, 4);
    get_out(1, "post_flush", 1'b0);

    for (int k = 0; k < NT; k++)
      write_coef(1, k, int'($urandom_range(255)) - 128, 1'b0, "cw_rand1");
    for (int g = 0; g < 5; g++) begin
      send_rand(1, 4);
      get_out(1, "rand1", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
